// File: rtl/nu7501_pkg.sv
// Shared types and defaults for the 7501-side bus arbiter: FSM state encoding,
// registered bus-control bundle and counter sizing helper.
package nu7501_pkg;

   localparam int unsigned DEF_WRITE_GRACE    = 3;
   localparam int unsigned DEF_MIN_CPU_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_CPU      = 3'd0,
      ST_STALL    = 3'd1,
      ST_HANDOVER = 3'd2,
      ST_DMA      = 3'd3,
      ST_RELEASE  = 3'd4,
      ST_COOLDOWN = 3'd5
   } arb_state_e;

   typedef struct packed {
      logic aec;
      logic rdy;
      logic gnt;
   } bus_ctl_t;

   localparam bus_ctl_t CTL_RESET = '{aec: 1'b1, rdy: 1'b1, gnt: 1'b0};

   function automatic bus_ctl_t decode_ctl(input arb_state_e s);
      bus_ctl_t c;
      c = CTL_RESET;
      case (s)
         ST_CPU:      c = '{aec: 1'b1, rdy: 1'b1, gnt: 1'b0};
         ST_STALL:    c = '{aec: 1'b1, rdy: 1'b0, gnt: 1'b0};
         ST_HANDOVER: c = '{aec: 1'b0, rdy: 1'b0, gnt: 1'b0};
         ST_DMA:      c = '{aec: 1'b0, rdy: 1'b0, gnt: 1'b1};
         ST_RELEASE:  c = '{aec: 1'b1, rdy: 1'b0, gnt: 1'b0};
         ST_COOLDOWN: c = '{aec: 1'b1, rdy: 1'b1, gnt: 1'b0};
         default:     c = CTL_RESET;
      endcase
      return c;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/bus_cycle_counter.sv
// Loadable down-counter that saturates at zero; last_o flags the final counted
// bus cycle (count of one, or an empty load).
module bus_cycle_counter
   import nu7501_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             last_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   assign last_o = (cnt_q == '0) || (cnt_q == WIDTH'(1));

endmodule

// File: rtl/bus_arbiter.sv
// Hands the 7501-side bus between the CPU and a DMA requester, stalling the CPU
// on a read cycle (or after a bounded write grace) before tristating it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// CPU      | CPU owns and runs the bus
// STALL    | RDY low, waiting for the CPU to freeze on a read
// HANDOVER | CPU address tristated, one turnaround cycle before grant
// DMA      | requester drives the bus
// RELEASE  | CPU address back on the bus, CPU still held
// COOLDOWN | CPU runs for a guaranteed number of cycles, requests ignored
module bus_arbiter
   import nu7501_pkg::*;
#(
   parameter int unsigned WRITE_GRACE    = DEF_WRITE_GRACE,
   parameter int unsigned MIN_CPU_CYCLES = DEF_MIN_CPU_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic r_w_6502,
   input  logic dma_req,
   output logic dma_gnt,
   output logic aec,
   output logic _rdy_7501,
   output logic grace_err
);

   localparam int unsigned GW = cnt_width(WRITE_GRACE);
   localparam int unsigned CW = cnt_width(MIN_CPU_CYCLES);
   localparam logic [GW-1:0] GRACE_LD = GW'(WRITE_GRACE);
   localparam logic [CW-1:0] COOL_LD  = CW'(MIN_CPU_CYCLES);

   arb_state_e state_q, state_d;
   bus_ctl_t   ctl_q;
   logic       grace_err_q, grace_err_d;
   logic       grace_load, grace_dec, grace_last;
   logic       cool_load, cool_dec, cool_last;

   bus_cycle_counter #(.WIDTH(GW)) u_grace_cnt (
      .clock      (clock),
      .reset      (reset),
      .load_i     (grace_load),
      .load_val_i (GRACE_LD),
      .dec_i      (grace_dec),
      .last_o     (grace_last)
   );

   bus_cycle_counter #(.WIDTH(CW)) u_cool_cnt (
      .clock      (clock),
      .reset      (reset),
      .load_i     (cool_load),
      .load_val_i (COOL_LD),
      .dec_i      (cool_dec),
      .last_o     (cool_last)
   );

   always_comb begin
      state_d     = state_q;
      grace_err_d = 1'b0;
      grace_load  = 1'b0;
      grace_dec   = 1'b0;
      cool_load   = 1'b0;
      cool_dec    = 1'b0;
      case (state_q)
         ST_CPU: begin
            if (dma_req) begin
               state_d    = ST_STALL;
               grace_load = 1'b1;
            end
         end
         ST_STALL: begin
            if (!dma_req) begin
               state_d = ST_CPU;
            end else if (r_w_6502) begin
               state_d = ST_HANDOVER;
            end else begin
               grace_dec = 1'b1;
               if (grace_last) begin
                  state_d     = ST_HANDOVER;
                  grace_err_d = 1'b1;
               end
            end
         end
         ST_HANDOVER: state_d = dma_req ? ST_DMA : ST_RELEASE;
         ST_DMA: begin
            if (!dma_req) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (MIN_CPU_CYCLES > 0) begin
               state_d   = ST_COOLDOWN;
               cool_load = 1'b1;
            end else begin
               state_d = ST_CPU;
            end
         end
         ST_COOLDOWN: begin
            cool_dec = 1'b1;
            // Last guaranteed CPU cycle doubles as the CPU-state request decision
            if (cool_last) begin
               if (dma_req) begin
                  state_d    = ST_STALL;
                  grace_load = 1'b1;
               end else begin
                  state_d = ST_CPU;
               end
            end
         end
         default: state_d = ST_CPU;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_CPU;
         ctl_q       <= CTL_RESET;
         grace_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctl_q       <= decode_ctl(state_d);
         grace_err_q <= grace_err_d;
      end
   end

   assign aec       = ctl_q.aec;
   assign _rdy_7501 = ctl_q.rdy;
   assign dma_gnt   = ctl_q.gnt;
   assign grace_err = grace_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: default-parameter instance checked against a
// vector table, plus a MIN_CPU_CYCLES=4 instance for the cooldown sequence.
module tb_bus_arbiter;

   logic clock = 1'b0;
   logic reset;
   logic r_w_6502;
   logic dma_req;
   logic gnt_a, aec_a, rdy_a, err_a;
   logic gnt_b, aec_b, rdy_b, err_b;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   bus_arbiter dut_a (
      .clock     (clock),
      .reset     (reset),
      .r_w_6502  (r_w_6502),
      .dma_req   (dma_req),
      .dma_gnt   (gnt_a),
      .aec       (aec_a),
      ._rdy_7501 (rdy_a),
      .grace_err (err_a)
   );

   bus_arbiter #(.WRITE_GRACE(3), .MIN_CPU_CYCLES(4)) dut_b (
      .clock     (clock),
      .reset     (reset),
      .r_w_6502  (r_w_6502),
      .dma_req   (dma_req),
      .dma_gnt   (gnt_b),
      .aec       (aec_b),
      ._rdy_7501 (rdy_b),
      .grace_err (err_b)
   );

   typedef struct {
      logic rst, req, rw;
      logic aec, rdy, gnt, err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      check("a gnt_with_aec", gnt_a & aec_a, 1'b0);
      check("a rdy_without_aec", rdy_a & ~aec_a, 1'b0);
      check("b gnt_with_aec", gnt_b & aec_b, 1'b0);
      check("b rdy_without_aec", rdy_b & ~aec_b, 1'b0);
   endtask

   task automatic add(input logic rst, input logic req, input logic rw,
                      input logic e_aec, input logic e_rdy, input logic e_gnt, input logic e_err);
      vec_t v;
      v.rst = rst; v.req = req; v.rw = rw;
      v.aec = e_aec; v.rdy = e_rdy; v.gnt = e_gnt; v.err = e_err;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset    = 1'b1;
      dma_req  = 1'b0;
      r_w_6502 = 1'b1;

      //   rst req rw   aec rdy gnt err
      add(1, 0, 1,   1, 1, 0, 0);   //  0 reset
      add(0, 1, 1,   1, 0, 0, 0);   //  1 STALL
      add(0, 1, 1,   0, 0, 0, 0);   //  2 HANDOVER on read
      add(0, 1, 1,   0, 0, 1, 0);   //  3 DMA
      add(0, 1, 1,   0, 0, 1, 0);   //  4
      add(0, 1, 1,   0, 0, 1, 0);   //  5
      add(0, 1, 1,   0, 0, 1, 0);   //  6
      add(0, 0, 1,   1, 0, 0, 0);   //  7 RELEASE
      add(0, 0, 1,   1, 1, 0, 0);   //  8 COOLDOWN
      add(0, 1, 1,   1, 1, 0, 0);   //  9 request ignored in cooldown
      add(0, 1, 1,   1, 0, 0, 0);   // 10 STALL right after 2 cooldown cycles
      add(0, 1, 0,   1, 0, 0, 0);   // 11 write 1
      add(0, 1, 0,   1, 0, 0, 0);   // 12 write 2
      add(0, 1, 0,   0, 0, 0, 1);   // 13 write 3: forced handover + err
      add(0, 1, 0,   0, 0, 1, 0);   // 14 DMA, err was one cycle
      add(0, 0, 0,   1, 0, 0, 0);   // 15 RELEASE
      add(0, 0, 0,   1, 1, 0, 0);   // 16 COOLDOWN
      add(0, 0, 0,   1, 1, 0, 0);   // 17
      add(0, 0, 0,   1, 1, 0, 0);   // 18 CPU
      add(0, 1, 0,   1, 0, 0, 0);   // 19 STALL
      add(0, 1, 0,   1, 0, 0, 0);   // 20 write 1
      add(0, 1, 0,   1, 0, 0, 0);   // 21 write 2
      add(0, 1, 1,   0, 0, 0, 0);   // 22 read: HANDOVER, no err
      add(0, 0, 1,   1, 0, 0, 0);   // 23 request gone: RELEASE
      add(0, 0, 1,   1, 1, 0, 0);   // 24 COOLDOWN
      add(0, 0, 1,   1, 1, 0, 0);   // 25
      add(0, 0, 1,   1, 1, 0, 0);   // 26 CPU
      add(0, 1, 0,   1, 0, 0, 0);   // 27 one-cycle pulse: STALL
      add(0, 0, 0,   1, 1, 0, 0);   // 28 abort beats write count
      add(0, 0, 0,   1, 1, 0, 0);   // 29 stays CPU
      add(0, 1, 1,   1, 0, 0, 0);   // 30 STALL
      add(0, 0, 1,   1, 1, 0, 0);   // 31 abort beats read

      foreach (vecs[i]) begin
         reset    = vecs[i].rst;
         dma_req  = vecs[i].req;
         r_w_6502 = vecs[i].rw;
         tick();
         check($sformatf("v%0d aec", i), aec_a, vecs[i].aec);
         check($sformatf("v%0d rdy", i), rdy_a, vecs[i].rdy);
         check($sformatf("v%0d gnt", i), gnt_a, vecs[i].gnt);
         check($sformatf("v%0d grace_err", i), err_a, vecs[i].err);
      end

      // Reset asserted mid-DMA takes effect without a clock edge
      dma_req  = 1'b1;
      r_w_6502 = 1'b1;
      tick(); tick(); tick();
      check("pre-reset gnt", gnt_a, 1'b1);
      reset = 1'b1;
      #1;
      check("async rst aec", aec_a, 1'b1);
      check("async rst rdy", rdy_a, 1'b1);
      check("async rst gnt", gnt_a, 1'b0);
      check("async rst err", err_a, 1'b0);
      check("async rst b rdy", rdy_b, 1'b1);
      check("async rst b aec", aec_b, 1'b1);
      dma_req = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("post-rst idle%0d rdy", k), rdy_a, 1'b1);
         check($sformatf("post-rst idle%0d gnt", k), gnt_a, 1'b0);
         check($sformatf("post-rst idle%0d aec", k), aec_a, 1'b1);
      end

      // First decision after reset release on the next edge
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      dma_req = 1'b1;
      tick();
      check("first-edge rdy", rdy_a, 1'b0);

      // MIN_CPU_CYCLES=4 instance, request re-asserted right after release
      reset   = 1'b1;
      dma_req = 1'b0;
      tick();
      reset   = 1'b0;
      dma_req = 1'b1;
      tick(); tick(); tick();
      check("b gnt in DMA", gnt_b, 1'b1);
      dma_req = 1'b0;
      tick();
      check("b release aec", aec_b, 1'b1);
      check("b release rdy", rdy_b, 1'b0);
      dma_req = 1'b1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rdy_b) n++;
         else break;
      end
      check_int("b cooldown cycles", n, 4);
      check("b stall aec", aec_b, 1'b1);
      check("b stall gnt", gnt_b, 1'b0);
      tick();
      check("b handover aec", aec_b, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
